// File: rtl/trace_pkg.sv
// Shared types and widths for the commit trace FIFO.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a per-entry cycle stamp.
package trace_pkg;

    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int RADDR_W = 5;
    localparam int DATA_W  = 32;
    localparam int STAMP_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } trace_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
`ifdef TRACE_TIMESTAMP_EN
        logic [STAMP_W-1:0] stamp;
`endif
    } trace_entry_t;

endpackage

// File: rtl/commit_trace_fifo_if.sv
// Commit-side inputs, trace output port and status of the commit trace FIFO.
// The master drives commits and out_ready; the slave (the FIFO) drives the rest.
interface commit_trace_fifo_if #(
    parameter int DEPTH = 16
);
    import trace_pkg::*;

    logic                     cap_en;
    logic                     commit_valid;
    logic [PC_W-1:0]          commit_pc;
    logic [INST_W-1:0]        commit_inst;
    logic                     rf_we;
    logic [RADDR_W-1:0]       rf_waddr;
    logic [DATA_W-1:0]        rf_wdata;

    logic                     out_valid;
    logic                     out_ready;
    logic [PC_W-1:0]          out_pc;
    logic [INST_W-1:0]        out_inst;
    logic                     out_we;
    logic [RADDR_W-1:0]       out_waddr;
    logic [DATA_W-1:0]        out_wdata;
    logic [STAMP_W-1:0]       out_stamp;

    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic [15:0]              overflow_cnt;
    logic                     done;

    modport master (
        output cap_en, commit_valid, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata,
        output out_ready,
        input  out_valid, out_pc, out_inst, out_we, out_waddr, out_wdata, out_stamp,
        input  full, empty, count, overflow_cnt, done
    );

    modport slave (
        input  cap_en, commit_valid, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata,
        input  out_ready,
        output out_valid, out_pc, out_inst, out_we, out_waddr, out_wdata, out_stamp,
        output full, empty, count, overflow_cnt, done
    );

endinterface

// File: rtl/trace_fifo_mem.sv
// First-word-fall-through storage for trace entries: circular buffer with
// power-of-two depth, wrapping pointers and an occupancy count of 0..DEPTH.
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  trace_entry_t           wr_data,
    input  logic                   rd_en,
    output trace_entry_t           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            wr_ok;
    logic            rd_ok;

    // A write into a full buffer is accepted only when the head leaves on the same edge.
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_fifo.sv
// Captures retired instructions inside a cycle window into a trace FIFO.
// Optional macro TRACE_TIMESTAMP_EN stores the cycle count with each entry.
module commit_trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int CAP_START = 1,
    parameter int CAP_END   = 152
) (
    input  logic                clk,
    input  logic                rst,
    commit_trace_fifo_if.slave  bus
);

    localparam logic [STAMP_W-1:0] START_C = STAMP_W'(CAP_START);
    localparam logic [STAMP_W-1:0] END_C   = STAMP_W'(CAP_END);

    trace_state_t             state_q;
    trace_state_t             state_d;
    logic [STAMP_W-1:0]       cycle_cnt;
    logic [15:0]              overflow_cnt;
    logic                     in_window;
    logic                     push_req;
    logic                     pop;
    logic                     drop;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    trace_entry_t             wr_entry;
    trace_entry_t             head;

    assign in_window = (cycle_cnt >= START_C) && (cycle_cnt < END_C);
    assign push_req  = (state_q == ST_CAPTURE) && bus.commit_valid && in_window;
    assign pop       = !empty && bus.out_ready;
    assign drop      = push_req && full && !pop;

    // Writes to $0 are architecturally invisible, so they are traced as non-writes.
    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = bus.commit_pc;
        wr_entry.inst  = bus.commit_inst;
        wr_entry.we    = bus.rf_we && (bus.rf_waddr != '0);
        wr_entry.waddr = bus.rf_waddr;
        wr_entry.wdata = bus.rf_wdata;
`ifdef TRACE_TIMESTAMP_EN
        wr_entry.stamp = cycle_cnt;
`endif
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_req),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cycle_cnt    <= '0;
            overflow_cnt <= '0;
        end else begin
            state_q   <= state_d;
            cycle_cnt <= cycle_cnt + STAMP_W'(1);
            if (drop && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    // DONE is terminal; only reset re-arms the capture.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cap_en) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!bus.cap_en || (cycle_cnt == END_C)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.out_valid    = !empty;
    assign bus.out_pc       = head.pc;
    assign bus.out_inst     = head.inst;
    assign bus.out_we       = head.we;
    assign bus.out_waddr    = head.waddr;
    assign bus.out_wdata    = head.wdata;
`ifdef TRACE_TIMESTAMP_EN
    assign bus.out_stamp    = head.stamp;
`else
    assign bus.out_stamp    = '0;
`endif
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.overflow_cnt = overflow_cnt;
    assign bus.done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Self-checking bench for commit_trace_fifo: random commits compared against a
// queue-based reference model, plus directed window, overflow and reset checks.
module tb_commit_trace_fifo;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CS    = 1;
    localparam int CE    = 152;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    commit_trace_fifo_if #(.DEPTH(DEPTH)) bus ();

    commit_trace_fifo #(
        .DEPTH     (DEPTH),
        .CAP_START (CS),
        .CAP_END   (CE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] stamp;
    } ref_entry_t;

    // Reference model: phase 0 idle, 1 capturing, 2 draining, 3 finished.
    ref_entry_t  mq[$];
    int unsigned mcyc;
    int          movf;
    int          phase;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mcyc  = 0;
        movf  = 0;
        phase = 0;
    endtask

    // Applies the rules for one rising edge using the inputs currently driven.
    task automatic modelStep();
        bit         was_empty;
        bit         pop;
        bit         push;
        ref_entry_t e;
        was_empty = (mq.size() == 0);
        pop  = !was_empty && (bus.out_ready === 1'b1);
        push = (phase == 1) && (bus.commit_valid === 1'b1) && (mcyc >= CS) && (mcyc < CE);
        if (pop) begin
            void'(mq.pop_front());
        end
        if (push) begin
            if (mq.size() < DEPTH) begin
                e.pc    = bus.commit_pc;
                e.inst  = bus.commit_inst;
                e.we    = bus.rf_we && (bus.rf_waddr != 5'd0);
                e.waddr = bus.rf_waddr;
                e.wdata = bus.rf_wdata;
                e.stamp = mcyc;
                mq.push_back(e);
            end else if (movf < 65535) begin
                movf++;
            end
        end
        if (phase == 0 && bus.cap_en) begin
            phase = 1;
        end else if (phase == 1 && (!bus.cap_en || mcyc == CE)) begin
            phase = 2;
        end else if (phase == 2 && was_empty) begin
            phase = 3;
        end
        mcyc++;
    endtask

    task automatic checkOutput(input string where);
        check({where, ".out_valid"}, bus.out_valid, mq.size() != 0);
        check({where, ".empty"}, bus.empty, mq.size() == 0);
        check({where, ".full"}, bus.full, mq.size() == DEPTH);
        check({where, ".count"}, bus.count, mq.size());
        check({where, ".overflow_cnt"}, bus.overflow_cnt, movf);
        check({where, ".done"}, bus.done, phase == 3);
        if (mq.size() != 0) begin
            check({where, ".out_pc"}, bus.out_pc, mq[0].pc);
            check({where, ".out_inst"}, bus.out_inst, mq[0].inst);
            check({where, ".out_we"}, bus.out_we, mq[0].we);
            check({where, ".out_waddr"}, bus.out_waddr, mq[0].waddr);
            check({where, ".out_wdata"}, bus.out_wdata, mq[0].wdata);
`ifdef TRACE_TIMESTAMP_EN
            check({where, ".out_stamp"}, bus.out_stamp, mq[0].stamp);
`endif
        end
`ifndef TRACE_TIMESTAMP_EN
        check({where, ".out_stamp"}, bus.out_stamp, 32'h0);
`endif
    endtask

    // Drives one cycle of inputs at the falling edge, then checks after the rising edge.
    task automatic applyStimulus(input bit cap, input bit cv, input bit rdy,
                                 input logic [31:0] pc, input logic [31:0] inst,
                                 input logic we, input logic [4:0] waddr,
                                 input logic [31:0] wdata);
        bus.cap_en       = cap;
        bus.commit_valid = cv;
        bus.out_ready    = rdy;
        bus.commit_pc    = pc;
        bus.commit_inst  = inst;
        bus.rf_we        = we;
        bus.rf_waddr     = waddr;
        bus.rf_wdata     = wdata;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("step");
        @(negedge clk);
    endtask

    task automatic randStep(input bit cap, input bit cv, input bit rdy);
        applyStimulus(cap, cv, rdy, $urandom, $urandom, 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), $urandom);
    endtask

    // Asserts reset between clock edges and checks its effect before any edge arrives.
    task automatic doReset();
        rst = 1'b1;
        #1;
        check("rst.empty", bus.empty, 1'b1);
        check("rst.full", bus.full, 1'b0);
        check("rst.count", bus.count, 0);
        check("rst.out_valid", bus.out_valid, 1'b0);
        check("rst.overflow_cnt", bus.overflow_cnt, 16'h0);
        check("rst.done", bus.done, 1'b0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.cap_en       = 1'b0;
        bus.commit_valid = 1'b0;
        bus.out_ready    = 1'b0;
        bus.commit_pc    = '0;
        bus.commit_inst  = '0;
        bus.rf_we        = 1'b0;
        bus.rf_waddr     = '0;
        bus.rf_wdata     = '0;
        rst              = 1'b1;

        doReset();

        // Fill with the consumer stalled: commits at cycles 1..20, four are dropped.
        for (int i = 0; i <= 20; i++) begin
            if (i == 1) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0013,
                              1'b1, 5'd0, 32'h0000_1234);
            end else begin
                randStep(1'b1, 1'b1, 1'b0);
            end
        end
        check("fill.full", bus.full, 1'b1);
        check("fill.count", bus.count, 16);
        check("fill.overflow_cnt", bus.overflow_cnt, 4);
        check("fill.x0_we", bus.out_we, 1'b0);
        check("fill.x0_wdata", bus.out_wdata, 32'h0000_1234);
        check("fill.head_pc", bus.out_pc, 32'h0000_1000);

        // Push and pop together while full.
        randStep(1'b1, 1'b1, 1'b1);
        check("fullpp.count", bus.count, 16);
        check("fullpp.overflow_cnt", bus.overflow_cnt, 4);

        // Random traffic through the end of the capture window.
        for (int i = 0; i < 140; i++) begin
            randStep(1'b1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 100 && phase != 3; i++) begin
            randStep(1'b1, 1'b1, 1'b1);
        end
        check("window.done", bus.done, 1'b1);
        for (int i = 0; i < 3; i++) begin
            randStep(1'b1, 1'b1, 1'b1);
        end
        check("window.done_holds", bus.done, 1'b1);
        check("window.empty", bus.empty, 1'b1);

        // Single commit at cycle 10 for the stamp.
        doReset();
        for (int i = 0; i <= 10; i++) begin
            randStep(1'b1, mcyc == 10, 1'b0);
        end
        check("stamp.out_valid", bus.out_valid, 1'b1);
`ifdef TRACE_TIMESTAMP_EN
        check("stamp.value", bus.out_stamp, 32'h0000_000A);
`else
        check("stamp.value", bus.out_stamp, 32'h0);
`endif

        // Reset in the middle of capture with five entries held.
        doReset();
        for (int i = 0; i < 6; i++) begin
            randStep(1'b1, 1'b1, 1'b0);
        end
        check("midrst.count_before", bus.count, 5);
        doReset();

        // Capture ended early by dropping cap_en, then drained with random back-pressure.
        for (int i = 0; i < 8; i++) begin
            randStep(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 200 && phase != 3; i++) begin
            randStep(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        end
        check("early.done", bus.done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
